// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg
//   Shared definitions for the SPI command sequencer:
//   - state_e     : sequencer state encoding
//   - CMD_*_DEF   : default command byte values
//   - is_cmd()    : helper that tells whether a byte is one of the two known commands
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4,
    ST_BUS   = 3'd5,
    ST_DRAIN = 3'd6
  } state_e;

  localparam logic [7:0] CMD_WR_DEF = 8'h02;
  localparam logic [7:0] CMD_RD_DEF = 8'h03;

  function automatic logic is_cmd(input logic [7:0] b,
                                  input logic [7:0] cmd_wr,
                                  input logic [7:0] cmd_rd);
    return (b == cmd_wr) || (b == cmd_rd);
  endfunction

endpackage

// File: rtl/spi_ctrl_bus_if.sv
// spi_ctrl_bus_if
//   Single-outstanding req/ack register bus master used by spi_cmd_ctrl.
//   Holds the request and its qualifiers until ack or timeout, runs the ack
//   timeout counter and captures read data for the MISO holding register.
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start_i         : launch an access (ignored while one is outstanding)
//   we_i/addr_i/wdata_i : access qualifiers sampled with start_i
//   done_o          : combinational, access acknowledged this cycle
//   tmo_o           : combinational, access timed out this cycle
//   reg_*           : register bus (req/we/addr/wdata out, ack/rdata in)
//   tx_data_o/tx_valid_o : captured read data and its 1-cycle update pulse
module spi_ctrl_bus_if
  import spi_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int ACK_TMO = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic              done_o,
  output logic              tmo_o,
  output logic              reg_req_o,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  input  logic              reg_ack_i,
  input  logic [7:0]        reg_rdata_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o
);

  localparam int CNT_W = (ACK_TMO < 2) ? 1 : $clog2(ACK_TMO + 1);
  // Count value of the last request cycle allowed before giving up.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TMO - 1);

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;

  // An ack in the last allowed cycle still counts as a completion.
  assign done_o = req_q & reg_ack_i;
  assign tmo_o  = req_q & ~reg_ack_i & (cnt_q == CNT_LAST);

  always_comb begin
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    if (req_q) begin
      if (done_o || tmo_o) begin
        req_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (done_o && !we_q) begin
        tx_data_d  = reg_rdata_i;
        tx_valid_d = 1'b1;
      end
    end else if (start_i) begin
      req_d   = 1'b1;
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign reg_req_o   = req_q;
  assign reg_we_o    = we_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl
//   Frame/command sequencer behind the SPI byte receiver. Decodes CMD / ADDR /
//   DATA bytes of a chip-select frame into burst register writes or reads with
//   auto-incrementing address. Read data goes to the MISO holding port.
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   cs_n_i        : synchronised chip select, low = frame active
//   byte_en_i     : 1-cycle strobe qualifying byte_i
//   byte_i        : received byte
//   reg_*         : single-outstanding req/ack register bus
//   tx_data_o     : read byte for the MISO shifter, tx_valid_o pulses on update
//   busy_o        : sequencer not idle
//   err_cmd_o     : pulse, unknown command byte
//   err_ovr_o     : pulse, byte arrived while a bus access was pending
//   err_tmo_o     : pulse, bus ack timeout
module spi_cmd_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] CMD_WR  = CMD_WR_DEF,
  parameter logic [7:0] CMD_RD  = CMD_RD_DEF,
  parameter int         ACK_TMO = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic              reg_req_o,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  input  logic              reg_ack_i,
  input  logic [7:0]        reg_rdata_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  output logic              busy_o,
  output logic              err_cmd_o,
  output logic              err_ovr_o,
  output logic              err_tmo_o
);

  state_e            state_q, state_d;
  logic              cs_n_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;            // burst direction, 1 = write
  logic              end_pend_q, end_pend_d; // frame ended while an access was in flight
  logic              err_cmd_q, err_cmd_d;
  logic              err_ovr_q, err_ovr_d;
  logic              err_tmo_q;

  logic              cs_fall, cs_rise, byte_take, frame_over;
  logic              bus_start, bus_done, bus_tmo;
  logic [ADDR_W-1:0] bus_addr, byte_addr;

  // cs_n_q resets low so a chip select already low at reset release is not
  // mistaken for the start of a frame.
  assign cs_fall    = cs_n_q & ~cs_n_i;
  assign cs_rise    = ~cs_n_q & cs_n_i;
  // A byte coinciding with the end of the frame is dropped.
  assign byte_take  = byte_en_i & ~cs_rise;
  assign byte_addr  = ADDR_W'(byte_i);
  assign frame_over = end_pend_q | cs_rise;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cs_n_q     <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      end_pend_q <= 1'b0;
      err_cmd_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_i;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      end_pend_q <= end_pend_d;
      err_cmd_q  <= err_cmd_d;
      err_ovr_q  <= err_ovr_d;
      err_tmo_q  <= bus_tmo;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    end_pend_d = end_pend_q;
    case (state_q)
      ST_IDLE: begin
        end_pend_d = 1'b0;
        if (cs_fall) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (byte_take) begin
          if (is_cmd(byte_i, CMD_WR, CMD_RD)) begin
            wr_d    = (byte_i == CMD_WR);
            state_d = ST_ADDR;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_ADDR: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (byte_take) begin
          addr_d  = byte_addr;
          // Reads prefetch the first location as soon as the address is known.
          state_d = wr_q ? ST_WDATA : ST_BUS;
        end
      end
      ST_WDATA, ST_RDATA: begin
        if (cs_rise)        state_d = ST_IDLE;
        else if (byte_take) state_d = ST_BUS;
      end
      ST_BUS: begin
        // The access always runs to completion; a frame end is only noted.
        if (cs_rise) end_pend_d = 1'b1;
        if (bus_done) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = frame_over ? ST_IDLE : (wr_q ? ST_WDATA : ST_RDATA);
        end else if (bus_tmo) begin
          state_d = frame_over ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus_start = 1'b0;
    bus_addr  = addr_q;
    err_cmd_d = 1'b0;
    err_ovr_d = 1'b0;
    case (state_q)
      ST_CMD:   err_cmd_d = byte_take & ~is_cmd(byte_i, CMD_WR, CMD_RD);
      ST_ADDR: begin
        bus_start = byte_take & ~wr_q;
        bus_addr  = byte_addr;
      end
      ST_WDATA, ST_RDATA: bus_start = byte_take;
      ST_BUS:   err_ovr_d = byte_take;
      default: ;
    endcase
  end

  spi_ctrl_bus_if #(
    .ADDR_W  (ADDR_W),
    .ACK_TMO (ACK_TMO)
  ) u_bus_if (
    .clk         (clk),
    .rst         (rst),
    .start_i     (bus_start),
    .we_i        (wr_q),
    .addr_i      (bus_addr),
    .wdata_i     (byte_i),
    .done_o      (bus_done),
    .tmo_o       (bus_tmo),
    .reg_req_o   (reg_req_o),
    .reg_we_o    (reg_we_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_ack_i   (reg_ack_i),
    .reg_rdata_i (reg_rdata_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o)
  );

  assign busy_o    = (state_q != ST_IDLE);
  assign err_cmd_o = err_cmd_q;
  assign err_ovr_o = err_ovr_q;
  assign err_tmo_o = err_tmo_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl
//   Drives SPI frames byte by byte, plays the register bus slave and compares
//   the observed bus accesses, read bytes and error pulses with a frame-level
//   model built from the command/address/data rules.
module tb_spi_cmd_ctrl;

  localparam int ACK_TMO = 15;
  localparam int NEVER   = 1000;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n_i;
  logic       byte_en_i;
  logic [7:0] byte_i;
  logic       reg_req_o;
  logic       reg_we_o;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_ack_i;
  logic [7:0] reg_rdata_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       busy_o;
  logic       err_cmd_o;
  logic       err_ovr_o;
  logic       err_tmo_o;

  int n_checks = 0;
  int n_fail   = 0;

  acc_t       obs_acc[$];
  acc_t       exp_acc[$];
  logic [7:0] obs_tx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rd_src[$];
  logic [7:0] frame_q[$];

  int ack_dly = 0;
  int ack_cnt = 0;
  int last_req_len = 0;
  int n_err_cmd = 0;
  int n_err_ovr = 0;
  int n_err_tmo = 0;
  int stab_err = 0;

  spi_cmd_ctrl #(
    .ADDR_W  (8),
    .CMD_WR  (8'h02),
    .CMD_RD  (8'h03),
    .ACK_TMO (ACK_TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cs_n_i      (cs_n_i),
    .byte_en_i   (byte_en_i),
    .byte_i      (byte_i),
    .reg_req_o   (reg_req_o),
    .reg_we_o    (reg_we_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_ack_i   (reg_ack_i),
    .reg_rdata_i (reg_rdata_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .busy_o      (busy_o),
    .err_cmd_o   (err_cmd_o),
    .err_ovr_o   (err_ovr_o),
    .err_tmo_o   (err_tmo_o)
  );

  always #5 clk = ~clk;

  // Bus slave and monitor: acks ack_dly cycles into each request, logs every
  // request at its first cycle, records tx bytes and error pulses.
  initial begin
    int   req_len;
    logic req_prev;
    acc_t hold;
    acc_t cur;
    req_len     = 0;
    req_prev    = 1'b0;
    hold        = '0;
    reg_ack_i   = 1'b0;
    reg_rdata_i = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_valid_o) obs_tx.push_back(tx_data_o);
      if (err_cmd_o)  n_err_cmd++;
      if (err_ovr_o)  n_err_ovr++;
      if (err_tmo_o)  n_err_tmo++;
      cur = {reg_we_o, reg_addr_o, reg_wdata_o};
      if (reg_req_o) begin
        if (!req_prev) begin
          hold = cur;
          obs_acc.push_back(cur);
          req_len = 0;
        end else if (cur != hold) begin
          stab_err++;
        end
        if (req_len == ack_dly) begin
          reg_ack_i = 1'b1;
          ack_cnt++;
          if (!reg_we_o && rd_src.size() > 0) reg_rdata_i = rd_src.pop_front();
          else                                reg_rdata_i = 8'($urandom);
        end else begin
          reg_ack_i   = 1'b0;
          reg_rdata_i = 8'($urandom);
        end
        req_len++;
      end else begin
        if (req_prev) last_req_len = req_len;
        reg_ack_i   = 1'b0;
        reg_rdata_i = 8'($urandom);
      end
      req_prev = reg_req_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_en_i = 1'b1;
    byte_i    = b;
    @(negedge clk);
    byte_en_i = 1'b0;
    byte_i    = 8'($urandom);
    tick(gap);
  endtask

  task automatic start_frame();
    cs_n_i = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input int gap);
    $display("frame: cmd %h, %0d bytes, ack delay %0d", frame_q[0], frame_q.size(), ack_dly);
    foreach (frame_q[i]) send_byte(frame_q[i], gap);
  endtask

  task automatic set_frame(input logic [31:0] bytes, input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic clear_logs();
    obs_acc.delete();
    obs_tx.delete();
    ack_cnt      = 0;
    last_req_len = 0;
    n_err_cmd    = 0;
    n_err_ovr    = 0;
    n_err_tmo    = 0;
  endtask

  // Frame-level reference: write bursts store each data byte at successive
  // addresses; read bursts read the start address, then one more per dummy byte.
  task automatic model_frame();
    logic [7:0] a;
    exp_acc.delete();
    if (frame_q.size() >= 2 && (frame_q[0] == 8'h02 || frame_q[0] == 8'h03)) begin
      a = frame_q[1];
      if (frame_q[0] == 8'h02) begin
        for (int i = 2; i < frame_q.size(); i++) begin
          exp_acc.push_back({1'b1, a, frame_q[i]});
          a = a + 8'd1;
        end
      end else begin
        for (int i = 1; i < frame_q.size(); i++) begin
          exp_acc.push_back({1'b0, a, 8'h00});
          a = a + 8'd1;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    cs_n_i    = 1'b1;
    byte_en_i = 1'b1;
    byte_i    = 8'h02;
    tick(3);
    n_checks++;
    if ({reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, tx_data_o, tx_valid_o,
         busy_o, err_cmd_o, err_ovr_o, err_tmo_o} !== 31'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h tx=%h txv=%b busy=%b errs=%b%b%b, required all 0",
               reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, tx_data_o, tx_valid_o,
               busy_o, err_cmd_o, err_ovr_o, err_tmo_o);
    end
    byte_en_i = 1'b0;
    rst       = 1'b0;
    tick(3);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy_o=%b, required 0", busy_o);
    end
  endtask

  task automatic test_write_burst();
    clear_logs();
    ack_dly = 1;
    set_frame(32'h0210AABB, 4);
    model_frame();
    start_frame();
    send_frame(8);
    cs_n_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_busy_after_cs: busy_o=%b, required 0", busy_o);
    end
    tick(2);
    n_checks++;
    if (obs_acc.size() != exp_acc.size()) begin
      n_fail++;
      $display("FAIL wr_count: %0d accesses, required %0d", obs_acc.size(), exp_acc.size());
    end
    for (int i = 0; i < exp_acc.size() && i < obs_acc.size(); i++) begin
      n_checks++;
      if (obs_acc[i] !== exp_acc[i]) begin
        n_fail++;
        $display("FAIL wr_access[%0d]: we=%b addr=%h data=%h, required we=%b addr=%h data=%h", i,
                 obs_acc[i].we, obs_acc[i].addr, obs_acc[i].data,
                 exp_acc[i].we, exp_acc[i].addr, exp_acc[i].data);
      end
    end
    n_checks++;
    if (ack_cnt != 2 || n_err_cmd != 0 || n_err_ovr != 0 || n_err_tmo != 0 || obs_tx.size() != 0) begin
      n_fail++;
      $display("FAIL wr_side_effects: acks=%0d errs=%0d/%0d/%0d tx=%0d, required acks=2 errs=0/0/0 tx=0",
               ack_cnt, n_err_cmd, n_err_ovr, n_err_tmo, obs_tx.size());
    end
  endtask

  task automatic test_read_burst();
    clear_logs();
    ack_dly = 2;
    rd_src.delete();
    rd_src.push_back(8'h5A);
    rd_src.push_back(8'h5B);
    rd_src.push_back(8'h5C);
    exp_tx = rd_src;
    set_frame(32'h03FE0000, 4);
    model_frame();
    start_frame();
    send_frame(8);
    cs_n_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_busy_after_cs: busy_o=%b, required 0", busy_o);
    end
    tick(2);
    n_checks++;
    if (obs_acc.size() != 3) begin
      n_fail++;
      $display("FAIL rd_count: %0d accesses, required 3", obs_acc.size());
    end
    for (int i = 0; i < exp_acc.size() && i < obs_acc.size(); i++) begin
      n_checks++;
      if (obs_acc[i].we !== 1'b0 || obs_acc[i].addr !== exp_acc[i].addr) begin
        n_fail++;
        $display("FAIL rd_access[%0d]: we=%b addr=%h, required we=0 addr=%h", i,
                 obs_acc[i].we, obs_acc[i].addr, exp_acc[i].addr);
      end
    end
    n_checks++;
    if (obs_tx.size() != exp_tx.size()) begin
      n_fail++;
      $display("FAIL rd_tx_count: %0d tx pulses, required %0d", obs_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) begin
      n_checks++;
      if (obs_tx[i] !== exp_tx[i]) begin
        n_fail++;
        $display("FAIL rd_tx[%0d]: tx_data=%h, required %h", i, obs_tx[i], exp_tx[i]);
      end
    end
  endtask

  task automatic test_bad_cmd();
    clear_logs();
    ack_dly = 0;
    set_frame({8'h7E, 24'($urandom)}, 4);
    start_frame();
    send_frame(6);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_cmd_drain_busy: busy_o=%b, required 1", busy_o);
    end
    cs_n_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_cmd_busy_after_cs: busy_o=%b, required 0", busy_o);
    end
    tick(2);
    n_checks++;
    if (n_err_cmd != 1 || obs_acc.size() != 0) begin
      n_fail++;
      $display("FAIL bad_cmd_result: err_cmd cycles=%0d accesses=%0d, required 1 and 0",
               n_err_cmd, obs_acc.size());
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    ack_dly = NEVER;
    set_frame(32'h00022055, 3);
    start_frame();
    send_frame(ACK_TMO + 5);
    send_byte(8'h66, 4);
    send_byte(8'h77, 4);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_drain_busy: busy_o=%b, required 1", busy_o);
    end
    cs_n_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_busy_after_cs: busy_o=%b, required 0", busy_o);
    end
    tick(2);
    n_checks++;
    if (last_req_len != ACK_TMO) begin
      n_fail++;
      $display("FAIL tmo_req_cycles: req high %0d cycles, required %0d", last_req_len, ACK_TMO);
    end
    n_checks++;
    if (n_err_tmo != 1) begin
      n_fail++;
      $display("FAIL tmo_pulse: err_tmo cycles=%0d, required 1", n_err_tmo);
    end
    n_checks++;
    if (obs_acc.size() != 1 || (obs_acc.size() == 1 && obs_acc[0] !== acc_t'({1'b1, 8'h20, 8'h55}))) begin
      n_fail++;
      $display("FAIL tmo_accesses: %0d accesses (first %h), required 1 write 20<-55",
               obs_acc.size(), (obs_acc.size() > 0) ? obs_acc[0] : acc_t'('0));
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d1;
    clear_logs();
    ack_dly = 5;
    d1 = 8'($urandom);
    start_frame();
    send_byte(8'h02, 8);
    send_byte(8'h30, 8);
    send_byte(d1, 0);
    send_byte(8'($urandom), 12);
    cs_n_i = 1'b1;
    tick(3);
    n_checks++;
    if (n_err_ovr != 1) begin
      n_fail++;
      $display("FAIL ovr_pulse: err_ovr cycles=%0d, required 1", n_err_ovr);
    end
    n_checks++;
    if (obs_acc.size() != 1 || ack_cnt != 1 ||
        (obs_acc.size() == 1 && obs_acc[0] !== acc_t'({1'b1, 8'h30, d1}))) begin
      n_fail++;
      $display("FAIL ovr_accesses: %0d accesses %0d acks, required one write 30<-%h",
               obs_acc.size(), ack_cnt, d1);
    end
  endtask

  task automatic test_cs_rise_in_bus();
    int waited;
    clear_logs();
    ack_dly = 6;
    start_frame();
    send_byte(8'h02, 8);
    send_byte(8'h40, 8);
    send_byte(8'h99, 1);
    cs_n_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1 || reg_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bus_cs_hold: busy=%b req=%b, required 1 and 1", busy_o, reg_req_o);
    end
    waited = 0;
    while (reg_req_o === 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited >= 40) begin
      n_fail++;
      $display("FAIL bus_cs_wait: req still high after %0d cycles, required drop", waited);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bus_cs_idle: busy_o=%b after access, required 0", busy_o);
    end
    n_checks++;
    if (ack_cnt != 1 || obs_acc.size() != 1 ||
        (obs_acc.size() == 1 && obs_acc[0] !== acc_t'({1'b1, 8'h40, 8'h99}))) begin
      n_fail++;
      $display("FAIL bus_cs_access: %0d acks %0d accesses, required one write 40<-99", ack_cnt, obs_acc.size());
    end
    tick(2);
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    ack_dly = NEVER;
    start_frame();
    send_byte(8'h02, 4);
    send_byte(8'h50, 4);
    send_byte(8'h11, 3);
    n_checks++;
    if (reg_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_pre: req=%b, required 1", reg_req_o);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, tx_data_o, tx_valid_o,
         busy_o, err_cmd_o, err_ovr_o, err_tmo_o} !== 31'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: req=%b we=%b addr=%h wdata=%h tx=%h txv=%b busy=%b, required all 0",
               reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, tx_data_o, tx_valid_o, busy_o);
    end
    rst = 1'b0;
    tick(2);
    // cs is still low: without a fresh falling edge the frame must be ignored.
    clear_logs();
    ack_dly = 0;
    send_byte(8'h02, 4);
    send_byte(8'h60, 4);
    send_byte(8'h77, 6);
    n_checks++;
    if (obs_acc.size() != 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL cs_low_at_release: %0d accesses busy=%b, required 0 and 0", obs_acc.size(), busy_o);
    end
    cs_n_i = 1'b1;
    tick(3);
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int         kind;
      int         len;
      logic [7:0] a;
      logic [7:0] cmd;
      clear_logs();
      kind    = $urandom_range(0, 2);
      len     = $urandom_range(1, 4);
      ack_dly = $urandom_range(0, 4);
      a       = ($urandom_range(0, 2) == 0) ? 8'hFE : 8'($urandom);
      frame_q.delete();
      rd_src.delete();
      if (kind == 0) begin
        cmd = 8'h02;
      end else if (kind == 1) begin
        cmd = 8'h03;
      end else begin
        do cmd = 8'($urandom); while (cmd == 8'h02 || cmd == 8'h03);
      end
      frame_q.push_back(cmd);
      frame_q.push_back(a);
      for (int i = 0; i < len; i++) begin
        if (kind == 1 && i == len - 1) break;
        frame_q.push_back(8'($urandom));
      end
      if (kind == 1) for (int i = 0; i < len; i++) rd_src.push_back(8'($urandom));
      exp_tx = rd_src;
      model_frame();
      start_frame();
      send_frame(ack_dly + 4);
      cs_n_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd%0d_busy: busy_o=%b after cs rise, required 0", it, busy_o);
      end
      tick(2);
      n_checks++;
      if (obs_acc.size() != exp_acc.size()) begin
        n_fail++;
        $display("FAIL rnd%0d_count: %0d accesses, required %0d", it, obs_acc.size(), exp_acc.size());
      end
      for (int i = 0; i < exp_acc.size() && i < obs_acc.size(); i++) begin
        n_checks++;
        if (obs_acc[i].we !== exp_acc[i].we || obs_acc[i].addr !== exp_acc[i].addr ||
            (exp_acc[i].we && obs_acc[i].data !== exp_acc[i].data)) begin
          n_fail++;
          $display("FAIL rnd%0d_access[%0d]: we=%b addr=%h data=%h, required we=%b addr=%h data=%h", it, i,
                   obs_acc[i].we, obs_acc[i].addr, obs_acc[i].data,
                   exp_acc[i].we, exp_acc[i].addr, exp_acc[i].data);
        end
      end
      n_checks++;
      if (obs_tx != exp_tx) begin
        n_fail++;
        $display("FAIL rnd%0d_tx: %0d tx bytes (first %h), required %0d (first %h)", it,
                 obs_tx.size(), (obs_tx.size() > 0) ? obs_tx[0] : 8'h00,
                 exp_tx.size(), (exp_tx.size() > 0) ? exp_tx[0] : 8'h00);
      end
      n_checks++;
      if (n_err_cmd != ((kind == 2) ? 1 : 0) || n_err_ovr != 0 || n_err_tmo != 0) begin
        n_fail++;
        $display("FAIL rnd%0d_errs: cmd/ovr/tmo=%0d/%0d/%0d, required %0d/0/0", it,
                 n_err_cmd, n_err_ovr, n_err_tmo, (kind == 2) ? 1 : 0);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    cs_n_i      = 1'b1;
    byte_en_i   = 1'b0;
    byte_i      = 8'h00;
    @(negedge clk);
    test_reset();
    test_write_burst();
    test_read_burst();
    test_bad_cmd();
    test_timeout();
    test_overrun();
    test_cs_rise_in_bus();
    test_reset_mid_frame();
    test_random();
    n_checks++;
    if (stab_err != 0) begin
      n_fail++;
      $display("FAIL bus_stability: %0d cycles with qualifiers changing under req, required 0", stab_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
